// File: rtl/scmp_useq.sv
// Microcode sequencer for the SC/MP core: drives the ROM address (mc_pc) from the
// ROM's own sequencing fields, with call/return stack, bus-wait stall and flush.
module scmp_useq #(
  parameter int PC_W    = 8,
  parameter int COND_W  = 5,
  parameter int STACK_D = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           stall,
  input  logic                           mc_decode,
  input  logic [PC_W-1:0]                op_pc,
  input  logic                           mc_call,
  input  logic                           mc_ret,
  input  logic [COND_W-1:0]              mc_cond_mask,
  input  logic [COND_W-1:0]              mc_cond_xor,
  input  logic [COND_W-1:0]              cond_in,
  input  logic [PC_W-1:0]                mc_nextpc,
  output logic [PC_W-1:0]                mc_pc,
  output logic                           cond,
  output logic [$clog2(STACK_D+1)-1:0]   stk_depth,
  output logic                           stk_err
);

  localparam int DEPTH_W = $clog2(STACK_D+1);
  localparam logic [DEPTH_W-1:0] FULL   = DEPTH_W'(STACK_D);
  localparam logic [PC_W-1:0]    PC_ONE = PC_W'(1);

  logic [PC_W-1:0]    stk [STACK_D];
  logic [PC_W-1:0]    top;
  logic [PC_W-1:0]    nxt_pc;
  logic [DEPTH_W-1:0] nxt_depth;
  logic               nxt_err;
  logic               push;
  logic [PC_W-1:0]    ret_addr;

  assign cond     = |((cond_in ^ mc_cond_xor) & mc_cond_mask);
  assign ret_addr = mc_pc + PC_ONE;

  // Top of stack is the entry just below the occupancy count.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_D; i++)
      if (stk_depth == DEPTH_W'(i + 1)) top = stk[i];
  end

  always_comb begin
    nxt_pc    = mc_pc;
    nxt_depth = stk_depth;
    nxt_err   = stk_err;
    push      = 1'b0;
    if (flush) begin
      nxt_pc    = '0;
      nxt_depth = '0;
    end else if (!stall) begin
      if (mc_decode) begin
        nxt_pc = op_pc;
      end else if (cond) begin
        nxt_pc = mc_pc + PC_ONE;
      end else if (mc_ret) begin
        if (stk_depth != '0) begin
          nxt_pc    = top;
          nxt_depth = stk_depth - 1'b1;
        end else begin
          nxt_pc  = '0;
          nxt_err = 1'b1;
        end
      end else if (mc_call) begin
        if (stk_depth < FULL) begin
          push      = 1'b1;
          nxt_pc    = mc_pc + mc_nextpc;
          nxt_depth = stk_depth + 1'b1;
        end else begin
          nxt_pc  = '0;
          nxt_err = 1'b1;
        end
      end else if (mc_nextpc == '0) begin
        nxt_pc = '0;
      end else begin
        nxt_pc = mc_pc + mc_nextpc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_pc     <= '0;
      stk_depth <= '0;
      stk_err   <= 1'b0;
      for (int i = 0; i < STACK_D; i++) stk[i] <= '0;
    end else begin
      mc_pc     <= nxt_pc;
      stk_depth <= nxt_depth;
      stk_err   <= nxt_err;
      for (int i = 0; i < STACK_D; i++)
        if (push && stk_depth == DEPTH_W'(i)) stk[i] <= ret_addr;
    end
  end

endmodule

// File: tb/tb_scmp_useq.sv
// Bench for scmp_useq: directed scenarios plus random control traffic, checked
// against a queue-based reference model of the sequencer.
module tb_scmp_useq;
  localparam int PC_W = 8, COND_W = 5, STACK_D = 4, DW = $clog2(STACK_D+1);

  logic              clk = 1'b0;
  logic              rst_n, flush, stall, mc_decode, mc_call, mc_ret;
  logic [PC_W-1:0]   op_pc, mc_nextpc, mc_pc;
  logic [COND_W-1:0] mc_cond_mask, mc_cond_xor, cond_in;
  logic              cond, stk_err;
  logic [DW-1:0]     stk_depth;

  scmp_useq #(.PC_W(PC_W), .COND_W(COND_W), .STACK_D(STACK_D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .mc_decode(mc_decode), .op_pc(op_pc), .mc_call(mc_call), .mc_ret(mc_ret),
    .mc_cond_mask(mc_cond_mask), .mc_cond_xor(mc_cond_xor), .cond_in(cond_in),
    .mc_nextpc(mc_nextpc), .mc_pc(mc_pc), .cond(cond),
    .stk_depth(stk_depth), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Reference state
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_stk[$];
  logic            m_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_cond();
    for (int i = 0; i < COND_W; i++)
      if (mc_cond_mask[i] && (cond_in[i] != mc_cond_xor[i])) return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    flush = 0; stall = 0; mc_decode = 0; mc_call = 0; mc_ret = 0;
    op_pc = '0; mc_nextpc = '0; mc_cond_mask = '0; mc_cond_xor = '0; cond_in = '0;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".pc"},    32'(mc_pc),     32'(m_pc));
    check_eq({tag, ".depth"}, 32'(stk_depth), m_stk.size());
    check_eq({tag, ".err"},   32'(stk_err),   32'(m_err));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    m_pc = '0; m_stk.delete(); m_err = 1'b0;
    #1;
    check_state(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One microinstruction: inputs already driven; advance model and DUT one clock.
  task automatic step(input string tag);
    logic c;
    #1;
    c = m_cond();
    check_eq({tag, ".cond"}, 32'(cond), 32'(c));
    if (flush) begin
      m_pc = '0;
      m_stk.delete();
    end else if (!stall) begin
      if (mc_decode)            m_pc = op_pc;
      else if (c)               m_pc = m_pc + 8'd1;
      else if (mc_ret) begin
        if (m_stk.size() > 0)   m_pc = m_stk.pop_back();
        else begin m_pc = '0; m_err = 1'b1; end
      end else if (mc_call) begin
        if (m_stk.size() < STACK_D) begin
          m_stk.push_back(m_pc + 8'd1);
          m_pc = m_pc + mc_nextpc;
        end else begin m_pc = '0; m_err = 1'b1; end
      end else if (mc_nextpc == 0) m_pc = '0;
      else                         m_pc = m_pc + mc_nextpc;
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic go_to(input logic [PC_W-1:0] pc);
    idle(); mc_decode = 1; op_pc = pc; step("dec");
  endtask

  initial begin
    idle();
    do_reset("reset");

    // Sequencing with wrap and return-to-fetch
    go_to(8'd3);
    idle(); mc_nextpc = 8'd1;  step("seq_inc");
    check_eq("seq_inc_abs", 32'(mc_pc), 32'd4);
    idle(); mc_nextpc = 8'hFE; step("seq_wrap");
    check_eq("seq_wrap_abs", 32'(mc_pc), 32'd2);
    idle(); mc_nextpc = 8'd0;  step("seq_zero");
    check_eq("seq_zero_abs", 32'(mc_pc), 32'd0);

    // Condition skip and miss
    go_to(8'd10);
    idle(); mc_cond_mask = 5'b00001; cond_in = 5'b00001; step("cond_hit");
    check_eq("cond_hit_abs", 32'(mc_pc), 32'd11);
    go_to(8'd10);
    idle(); mc_cond_mask = 5'b00001; cond_in = 5'b00001; mc_cond_xor = 5'b00001; step("cond_miss");
    check_eq("cond_miss_abs", 32'(mc_pc), 32'd0);

    // Call / return
    go_to(8'h20);
    idle(); mc_call = 1; mc_nextpc = 8'h10; step("call");
    check_eq("call_abs", 32'(mc_pc), 32'h30);
    idle(); mc_ret = 1; step("ret");
    check_eq("ret_abs", 32'(mc_pc), 32'h21);

    // Overflow on the 5th nested call
    for (int i = 0; i < 5; i++) begin
      idle(); mc_call = 1; mc_nextpc = 8'd2; step("ovf_call");
    end
    check_eq("ovf_err", 32'(stk_err), 32'd1);
    check_eq("ovf_pc", 32'(mc_pc), 32'd0);

    // Underflow after reset
    do_reset("reset2");
    idle(); mc_ret = 1; step("udf");
    check_eq("udf_err", 32'(stk_err), 32'd1);
    do_reset("reset3");

    // Stall holds a pending decode
    go_to(8'd5);
    idle(); stall = 1; mc_decode = 1; op_pc = 8'h40; step("stall1");
    step("stall2");
    check_eq("stall_held", 32'(mc_pc), 32'd5);
    stall = 0; step("unstall");
    check_eq("unstall_abs", 32'(mc_pc), 32'h40);

    // Flush overrides stall
    idle(); mc_call = 1; mc_nextpc = 8'd3; step("fcall1");
    step("fcall2");
    idle(); flush = 1; stall = 1; step("flush");

    // Asynchronous reset with no clock edge, mid-call
    idle(); mc_call = 1; mc_nextpc = 8'd7; step("pre_rst");
    rst_n = 1'b0;
    #1;
    check_eq("arst_pc",    32'(mc_pc),     32'd0);
    check_eq("arst_depth", 32'(stk_depth), 32'd0);
    check_eq("arst_err",   32'(stk_err),   32'd0);
    do_reset("reset4");

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      flush        = ($urandom_range(0, 31) == 0);
      stall        = ($urandom_range(0, 7) == 0);
      mc_decode    = ($urandom_range(0, 7) == 0);
      mc_call      = ($urandom_range(0, 3) == 0);
      mc_ret       = ($urandom_range(0, 3) == 0);
      op_pc        = 8'($urandom);
      mc_nextpc    = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      mc_cond_mask = 5'($urandom & $urandom & $urandom);
      mc_cond_xor  = 5'($urandom);
      cond_in      = 5'($urandom);
      step("rnd");
      if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
